ascii_height_parser: RTL and testbench

ASCII_HEIGHT_PARSER -- requirements
Module: ascii_height_parser

---
 rtl/aoc_pkg.sv | 17 +
 rtl/ascii_height_parser_if.sv | 26 ++
 rtl/decimal_accumulator.sv | 18 +
 rtl/ascii_height_parser.sv | 105 ++++++++++
 tb/tb_ascii_height_parser.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/aoc_pkg.sv
// rtl/aoc_pkg.sv - shared constants and parser state type for the height parser
package aoc_pkg;

  localparam int HEIGHT_W = 16;

  localparam logic [7:0] ZERO = 8'h30;
  localparam logic [7:0] NINE = 8'h39;
  localparam logic [7:0] LF   = 8'h0A;
  localparam logic [7:0] CR   = 8'h0D;

  typedef enum logic [1:0] {
    IDLE,
    DIGITS,
    SKIP
  } parser_state_e;

endpackage

// File: rtl/ascii_height_parser_if.sv
// rtl/ascii_height_parser_if.sv - byte stream in, parsed heights and status out
interface ascii_height_parser_if #(
  parameter int HEIGHT_W = aoc_pkg::HEIGHT_W
);

  logic                in_valid;
  logic                in_ready;
  logic [7:0]          in_byte;
  logic                eof;
  logic                en;
  logic [HEIGHT_W-1:0] height;
  logic [15:0]         count;
  logic                err_char;
  logic                err_ovf;

  modport master (
    output in_valid, in_byte, eof,
    input  in_ready, en, height, count, err_char, err_ovf
  );

  modport slave (
    input  in_valid, in_byte, eof,
    output in_ready, en, height, count, err_char, err_ovf
  );

endinterface

// File: rtl/decimal_accumulator.sv
// rtl/decimal_accumulator.sv - acc*10 + digit with overflow detection
module decimal_accumulator #(
  parameter int HEIGHT_W = aoc_pkg::HEIGHT_W
) (
  input  logic [HEIGHT_W-1:0] acc,
  input  logic [3:0]          digit,
  output logic [HEIGHT_W-1:0] next_acc,
  output logic                ovf
);

  // Four extra bits always hold (2^W-1)*10+9 without wrapping.
  logic [HEIGHT_W+3:0] wide;

  assign wide     = ({4'b0000, acc} * (HEIGHT_W+4)'(10)) + (HEIGHT_W+4)'(digit);
  assign next_acc = wide[HEIGHT_W-1:0];
  assign ovf      = |wide[HEIGHT_W+3:HEIGHT_W];

endmodule

// File: rtl/ascii_height_parser.sv
// rtl/ascii_height_parser.sv - parses LF-separated decimal heights from an ASCII byte stream
module ascii_height_parser
  import aoc_pkg::*;
#(
  parameter int HEIGHT_W = aoc_pkg::HEIGHT_W
) (
  input logic                  clk,
  input logic                  rst_n,
  ascii_height_parser_if.slave bus
);

  parser_state_e       state, state_n;
  logic [HEIGHT_W-1:0] acc, acc_n, mac_acc, emit_val;
  logic                mac_ovf, accept, is_digit, emit, set_char, set_ovf;
  logic                in_ready, en, err_char, err_ovf;
  logic [HEIGHT_W-1:0] height;
  logic [15:0]         count;

  decimal_accumulator #(.HEIGHT_W(HEIGHT_W)) u_mac (
    .acc      (acc),
    .digit    (bus.in_byte[3:0]),
    .next_acc (mac_acc),
    .ovf      (mac_ovf)
  );

  assign accept   = bus.in_valid && in_ready;
  assign is_digit = (bus.in_byte >= ZERO) && (bus.in_byte <= NINE);

  always_comb begin
    state_n  = state;
    acc_n    = acc;
    emit     = 1'b0;
    emit_val = acc;
    set_char = 1'b0;
    set_ovf  = 1'b0;

    if (accept && bus.in_byte != CR) begin
      case (state)
        IDLE, DIGITS: begin
          if (is_digit) begin
            if (mac_ovf) begin
              set_ovf = 1'b1;
              acc_n   = '0;
              state_n = SKIP;
            end else begin
              acc_n   = mac_acc;
              state_n = DIGITS;
            end
          end else if (bus.in_byte == LF) begin
            emit    = (state == DIGITS);
            acc_n   = '0;
            state_n = IDLE;
          end else begin
            set_char = 1'b1;
            acc_n    = '0;
            state_n  = SKIP;
          end
        end
        default: begin
          if (bus.in_byte == LF) state_n = IDLE;
        end
      endcase
    end

    // eof terminates whatever state the byte (if any) left behind.
    if (bus.eof) begin
      if (state_n == DIGITS) begin
        emit     = 1'b1;
        emit_val = acc_n;
      end
      acc_n   = '0;
      state_n = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      en       <= 1'b0;
      height   <= '0;
      count    <= '0;
      err_char <= 1'b0;
      err_ovf  <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      state    <= state_n;
      acc      <= acc_n;
      en       <= emit;
      in_ready <= 1'b1;
      if (emit) height <= emit_val;
      if (emit && count != 16'hFFFF) count <= count + 16'd1;
      if (set_char) err_char <= 1'b1;
      if (set_ovf) err_ovf <= 1'b1;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.en       = en;
  assign bus.height   = height;
  assign bus.count    = count;
  assign bus.err_char = err_char;
  assign bus.err_ovf  = err_ovf;

endmodule

// File: tb/tb_ascii_height_parser.sv
// tb/tb_ascii_height_parser.sv - directed self-checking bench for ascii_height_parser
module tb_ascii_height_parser;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  int heights[$];
  int en_cycles[$];
  int term_cycles[$];

  ascii_height_parser_if #(.HEIGHT_W(16)) bus ();

  ascii_height_parser #(.HEIGHT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && bus.en === 1'b1) begin
      heights.push_back(int'(bus.height));
      en_cycles.push_back(cyc);
    end
  end

  function automatic int h_at(input int i);
    return (heights.size() > i) ? heights[i] : -1;
  endfunction

  function automatic int c_at(input int i);
    return (en_cycles.size() > i) ? en_cycles[i] : -1;
  endfunction

  function automatic int t_at(input int i);
    return (term_cycles.size() > i) ? term_cycles[i] + 1 : -2;
  endfunction

  task automatic send(input logic [7:0] b, input logic e);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    bus.eof      = e;
    if (b == 8'h0A || e) term_cycles.push_back(cyc);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i], 1'b0);
  endtask

  task automatic send_eof();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.eof      = 1'b1;
    term_cycles.push_back(cyc);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.eof      = 1'b0;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.eof      = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    heights.delete();
    en_cycles.delete();
    term_cycles.delete();
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.en !== 1'b0) begin n_bad++; $display("FAIL reset_en got %b want 0", bus.en); end
    n_cmp++; if (bus.height !== 16'd0) begin n_bad++; $display("FAIL reset_height got %0d want 0", bus.height); end
    n_cmp++; if (bus.count !== 16'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", bus.count); end
    n_cmp++; if ({bus.err_char, bus.err_ovf} !== 2'b00) begin n_bad++; $display("FAIL reset_flags got %b want 00", {bus.err_char, bus.err_ovf}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL ready_before_edge got %b want 0", bus.in_ready); end
    @(posedge clk);
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_edge got %b want 1", bus.in_ready); end
  endtask

  task automatic test_two_values();
    do_reset();
    send_str("199\n200\n");
    idle(3);
    n_cmp++; if (heights.size() !== 2) begin n_bad++; $display("FAIL two_en_count got %0d want 2", heights.size()); end
    n_cmp++; if (h_at(0) !== 199) begin n_bad++; $display("FAIL two_h0 got %0d want 199", h_at(0)); end
    n_cmp++; if (h_at(1) !== 200) begin n_bad++; $display("FAIL two_h1 got %0d want 200", h_at(1)); end
    n_cmp++; if (c_at(0) !== t_at(0)) begin n_bad++; $display("FAIL two_lat0 got cycle %0d want %0d", c_at(0), t_at(0)); end
    n_cmp++; if (c_at(1) !== t_at(1)) begin n_bad++; $display("FAIL two_lat1 got cycle %0d want %0d", c_at(1), t_at(1)); end
    n_cmp++; if (bus.count !== 16'd2) begin n_bad++; $display("FAIL two_count got %0d want 2", bus.count); end
    n_cmp++; if (bus.height !== 16'd200) begin n_bad++; $display("FAIL two_height_held got %0d want 200", bus.height); end
  endtask

  task automatic test_cr_blank_eof();
    do_reset();
    send_str("7\r\n\n\n42");
    send_eof();
    idle(3);
    n_cmp++; if (heights.size() !== 2) begin n_bad++; $display("FAIL crb_en_count got %0d want 2", heights.size()); end
    n_cmp++; if (h_at(0) !== 7) begin n_bad++; $display("FAIL crb_h0 got %0d want 7", h_at(0)); end
    n_cmp++; if (h_at(1) !== 42) begin n_bad++; $display("FAIL crb_h1 got %0d want 42", h_at(1)); end
    n_cmp++; if (bus.count !== 16'd2) begin n_bad++; $display("FAIL crb_count got %0d want 2", bus.count); end
    n_cmp++; if (bus.err_char !== 1'b0) begin n_bad++; $display("FAIL crb_err_char got %b want 0", bus.err_char); end
  endtask

  task automatic test_overflow();
    do_reset();
    send_str("65535\n65536\n9\n");
    idle(3);
    n_cmp++; if (heights.size() !== 2) begin n_bad++; $display("FAIL ovf_en_count got %0d want 2", heights.size()); end
    n_cmp++; if (h_at(0) !== 65535) begin n_bad++; $display("FAIL ovf_h0 got %0d want 65535", h_at(0)); end
    n_cmp++; if (h_at(1) !== 9) begin n_bad++; $display("FAIL ovf_h1 got %0d want 9", h_at(1)); end
    n_cmp++; if (bus.err_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b want 1", bus.err_ovf); end
    n_cmp++; if (bus.err_char !== 1'b0) begin n_bad++; $display("FAIL ovf_char_flag got %b want 0", bus.err_char); end
    n_cmp++; if (bus.count !== 16'd2) begin n_bad++; $display("FAIL ovf_count got %0d want 2", bus.count); end
  endtask

  task automatic test_bad_char();
    do_reset();
    send_str("1a2\n5\n");
    idle(3);
    n_cmp++; if (heights.size() !== 1) begin n_bad++; $display("FAIL chr_en_count got %0d want 1", heights.size()); end
    n_cmp++; if (h_at(0) !== 5) begin n_bad++; $display("FAIL chr_h0 got %0d want 5", h_at(0)); end
    n_cmp++; if (bus.err_char !== 1'b1) begin n_bad++; $display("FAIL chr_flag got %b want 1", bus.err_char); end
    n_cmp++; if (bus.err_ovf !== 1'b0) begin n_bad++; $display("FAIL chr_ovf_flag got %b want 0", bus.err_ovf); end
    n_cmp++; if (bus.count !== 16'd1) begin n_bad++; $display("FAIL chr_count got %0d want 1", bus.count); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    send_str("12");
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL mrst_async_ready got %b want 0", bus.in_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_str("3\n");
    idle(3);
    n_cmp++; if (heights.size() !== 1) begin n_bad++; $display("FAIL mrst_en_count got %0d want 1", heights.size()); end
    n_cmp++; if (h_at(0) !== 3) begin n_bad++; $display("FAIL mrst_h0 got %0d want 3", h_at(0)); end
    n_cmp++; if (bus.count !== 16'd1) begin n_bad++; $display("FAIL mrst_count got %0d want 1", bus.count); end
    n_cmp++; if ({bus.err_char, bus.err_ovf} !== 2'b00) begin n_bad++; $display("FAIL mrst_flags got %b want 00", {bus.err_char, bus.err_ovf}); end
  endtask

  task automatic test_digit_with_eof();
    do_reset();
    send(8'h34, 1'b0);
    send(8'h38, 1'b1);
    idle(3);
    n_cmp++; if (heights.size() !== 1) begin n_bad++; $display("FAIL deof_en_count got %0d want 1", heights.size()); end
    n_cmp++; if (h_at(0) !== 48) begin n_bad++; $display("FAIL deof_h0 got %0d want 48", h_at(0)); end
    n_cmp++; if (c_at(0) !== t_at(0)) begin n_bad++; $display("FAIL deof_lat got cycle %0d want %0d", c_at(0), t_at(0)); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send(8'h35, 1'b0);
    send(8'h0A, 1'b1);
    send(8'h31, 1'b1);
    send(8'h32, 1'b1);
    send(8'h78, 1'b0);
    send(8'h33, 1'b1);
    send_str("6\n");
    idle(3);
    n_cmp++; if (heights.size() !== 4) begin n_bad++; $display("FAIL b2b_en_count got %0d want 4", heights.size()); end
    n_cmp++; if (h_at(0) !== 5) begin n_bad++; $display("FAIL b2b_h0 got %0d want 5", h_at(0)); end
    n_cmp++; if (h_at(1) !== 1) begin n_bad++; $display("FAIL b2b_h1 got %0d want 1", h_at(1)); end
    n_cmp++; if (h_at(2) !== 2) begin n_bad++; $display("FAIL b2b_h2 got %0d want 2", h_at(2)); end
    n_cmp++; if (h_at(3) !== 6) begin n_bad++; $display("FAIL b2b_h3 got %0d want 6", h_at(3)); end
    n_cmp++; if (c_at(2) !== c_at(1) + 1) begin n_bad++; $display("FAIL b2b_consecutive got cycle %0d want %0d", c_at(2), c_at(1) + 1); end
    n_cmp++; if (bus.count !== 16'd4) begin n_bad++; $display("FAIL b2b_count got %0d want 4", bus.count); end
    n_cmp++; if (bus.err_char !== 1'b1) begin n_bad++; $display("FAIL b2b_err_char got %b want 1", bus.err_char); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
    bus.eof      = 1'b0;
    test_reset();
    test_two_values();
    test_cr_blank_eof();
    test_overflow();
    test_bad_char();
    test_mid_reset();
    test_digit_with_eof();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
